lfsr_8bit_checker: RTL
======================

LFSR_8BIT_CHECKER -- requirements
Module: lfsr_8bit_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words needed after the seed to declare lock (range 1..15).
REQ-002 SHALL have parameter UNLOCK_COUNT, default 3: consecutive mismatching words while locked that force loss of lock (range 1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_data carries a sequence word this cycle.
REQ-006 SHALL have port in_data, input, 8: received LFSR word.
REQ-007 SHALL have port clr_count, input, 1: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1: checker is synchronised to the sequence.
REQ-009 SHALL have port err, output, 1: one-cycle pulse, a locked-state word mismatched.
REQ-010 SHALL have port err_count, output, 16: saturating count of locked-state mismatches.

Function
REQ-011 SHALL define next(s) = {s[1]^s[4]^s[6]^s[7], s[7:1]}, i.e. 8-bit right shift with feedback into bit 7.
REQ-012 SHALL implement three states: HUNT, SYNC, LOCKED; cycles with in_valid=0 change no state, counter or prediction.
REQ-013 SHALL, in HUNT on a valid word: if in_data != 0x00, load it as the prediction seed, clear the match counter, go to SYNC; if in_data = 0x00, stay in HUNT.
REQ-014 SHALL, in SYNC on a valid word: on in_data = next(seed), increment the match counter and set seed to in_data; on reaching LOCK_COUNT, go to LOCKED.
REQ-015 SHALL, in SYNC on a mismatch: reseed from in_data and clear the match counter, staying in SYNC; if in_data = 0x00, go to HUNT instead.
REQ-016 SHALL, in LOCKED on a valid word: compare in_data with next(prediction), then advance the prediction to next(prediction) whether or not it matched (flywheel, no reseed).
REQ-017 SHALL, in LOCKED on a match: clear the miss counter.
REQ-018 SHALL, in LOCKED on a mismatch: pulse err and increment both err_count and the miss counter.
REQ-019 SHALL, when the miss counter reaches UNLOCK_COUNT, go to HUNT.
REQ-020 SHALL never count mismatches in HUNT or SYNC as errors.
REQ-021 SHALL register locked, err and err_count; each reflects the word accepted on the previous rising edge (latency 1 cycle).
REQ-022 SHALL assert locked exactly while the state is LOCKED.
REQ-023 SHALL saturate err_count at 0xFFFF (no wrap).
REQ-024 SHALL give clr_count priority over a simultaneous increment: err_count becomes 0 and the err pulse is still issued.
REQ-025 SHALL produce the reference sequence from seed 0x8A: 0x8A, 0x45, 0xA2, 0x51, 0x28, 0x14, 0x8A (period 6).

Reset
REQ-026 SHALL, while reset_n=0, immediately force state HUNT and set locked=0, err=0 and err_count=0x0000; match counter, miss counter and prediction SHALL be cleared.
REQ-027 SHALL, after reset_n is asserted mid-operation in any state, resume from HUNT on the first clock edge after reset_n rises.

Verification
REQ-028 SHALL check: after reset, drive in_valid=1 with 8A,45,A2,51,28 on consecutive cycles -> locked=1 the cycle after 0x28; err never asserted; err_count=0.
REQ-029 SHALL check: when locked and 0x14 is expected, drive 0x00, then 0x8A -> err=1 for exactly one cycle; err_count=1; locked stays 1; 0x8A matches.
REQ-030 SHALL check: when locked, drive three consecutive wrong words (0x00, 0xFF, 0x33) -> err_count=3; locked=0 after the third; 0x00 input in HUNT is ignored.
REQ-031 SHALL check: drive the REQ-028 stream with in_valid=0 for 2 cycles between each word and garbage on in_data while invalid -> same lock result, no err.
REQ-032 SHALL check: when locked with err_count=2, pulse reset_n low between clock edges -> locked=0 and err_count=0 before the next edge.
REQ-033 SHALL check: drive a mismatch with clr_count=1 in the same cycle -> err=1 and err_count=0; force saturation at 0xFFFF, then a further error -> err_count stays 0xFFFF.

Source files
------------

// File: rtl/lfsr_8bit_checker_if.sv
// Word stream and status bundle for the 8-bit LFSR sequence checker.
// The source drives the word stream; the checker drives the status.
interface lfsr_8bit_checker_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clr_count;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_data, clr_count,
        input  locked, err, err_count
    );

    modport slave (
        input  in_valid, in_data, clr_count,
        output locked, err, err_count
    );
endinterface

// File: rtl/lfsr_8bit_checker.sv
// Locks onto an 8-bit LFSR word stream (HUNT -> SYNC -> LOCKED).
// Once locked it flywheels the prediction and counts word errors.
module lfsr_8bit_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    lfsr_8bit_checker_if.slave  bus
);
    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[1] ^ s[4] ^ s[6] ^ s[7], s[7:1]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  pred_q, pred_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        err_q, err_d;
    logic [15:0] errcnt_q, errcnt_d;
    logic [7:0]  nxt;
    logic        hit;

    assign nxt = lfsr_next(pred_q);
    assign hit = (bus.in_data == nxt);

    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        match_d  = match_q;
        miss_d   = miss_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        if (bus.in_valid) begin
            case (state_q)
                S_HUNT: begin
                    if (bus.in_data != 8'h00) begin
                        pred_d  = bus.in_data;
                        match_d = 4'd0;
                        state_d = S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (hit) begin
                        match_d = match_q + 4'd1;
                        pred_d  = bus.in_data;
                        if (match_q + 4'd1 == LOCK_N) begin
                            state_d = S_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        // A zero word can never seed a useful prediction.
                        match_d = 4'd0;
                        if (bus.in_data == 8'h00) state_d = S_HUNT;
                        else                      pred_d  = bus.in_data;
                    end
                end
                S_LOCKED: begin
                    pred_d = nxt;
                    if (hit) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (miss_q + 4'd1 == UNLOCK_N) state_d = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
        if (bus.clr_count)                         errcnt_d = 16'h0000;
        else if (err_d && errcnt_q != 16'hFFFF)    errcnt_d = errcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_HUNT;
            pred_q   <= 8'h00;
            match_q  <= 4'd0;
            miss_q   <= 4'd0;
            err_q    <= 1'b0;
            errcnt_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.locked    = (state_q == S_LOCKED);
    assign bus.err       = err_q;
    assign bus.err_count = errcnt_q;
endmodule
